// File: rtl/fix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fix_pkg : shared FSM states, BCD constants and helpers for FIX seq allocation
// Rev 1.0
// ---------------------------------------------------------------------------
package fix_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int          BCD_DIGIT_W      = 4;
  localparam int          BCD_MAX_DIGITS   = 16;
  localparam logic [23:0] INIT_SEQ_DEFAULT = 24'h000002;

  // Checks the low 'digits' nibbles; callers zero-extend narrower values.
  function automatic logic bcd_is_valid(input logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] value,
                                        input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && value[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_incr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_incr : combinational DIGITS-wide BCD +1 with wrap-out on all-9s
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_incr
  import fix_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] din,
  output logic [BCD_DIGIT_W*DIGITS-1:0] dout,
  output logic                          wrap_out
);

  always_comb begin
    logic       c;
    logic [3:0] d;
    c    = 1'b1;
    d    = 4'd0;
    dout = din;
    for (int i = 0; i < DIGITS; i++) begin
      d = din[BCD_DIGIT_W*i +: BCD_DIGIT_W];
      if (c) begin
        if (d == 4'd9) begin
          dout[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'd0;
        end else begin
          dout[BCD_DIGIT_W*i +: BCD_DIGIT_W] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    wrap_out = c;
  end

endmodule
`default_nettype wire

// File: rtl/fix_seq_alloc_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fix_seq_alloc_arbiter : round-robin allocator of unique FIX MsgSeqNum values
// Rev 1.0
// ---------------------------------------------------------------------------
module fix_seq_alloc_arbiter
  import fix_pkg::*;
#(
  parameter int                            NUM_REQ  = 4,
  parameter int                            DIGITS   = 6,
  parameter logic [BCD_DIGIT_W*DIGITS-1:0] INIT_SEQ = (BCD_DIGIT_W*DIGITS)'(INIT_SEQ_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  output logic [NUM_REQ-1:0]              grant,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   seq_num,
  input  logic                            pause,
  input  logic                            load_req,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   load_num,
  output logic                            load_ack,
  output logic                            load_err,
  output logic                            wrap_flag,
  output logic                            busy
);

  localparam int SEQ_W = BCD_DIGIT_W * DIGITS;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state, w_state_nxt;
  logic [SEQ_W-1:0]   r_counter, r_load_num;
  logic [PTR_W-1:0]   r_rr_ptr, w_pick_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_req_eff;
  logic               w_pick_valid, w_do_grant, w_do_capture, w_load_ok;
  logic [SEQ_W-1:0]   w_incr_sum, w_counter_nxt;
  logic               w_wrap;

  bcd_incr #(.DIGITS(DIGITS)) u_incr (
    .din      (r_counter),
    .dout     (w_incr_sum),
    .wrap_out (w_wrap)
  );

  // Past all-9s the counter skips zero so 0 is never issued.
  assign w_counter_nxt = w_wrap ? SEQ_W'(1) : w_incr_sum;
  assign w_load_ok     = bcd_is_valid((BCD_DIGIT_W*BCD_MAX_DIGITS)'(r_load_num), DIGITS);
  assign w_req_eff     = req & ~grant;
  assign busy          = (r_state == ST_LOAD) | pause;

  // First eligible requester at or after rr_ptr; descending scan so lowest offset wins.
  always_comb begin
    int idx;
    int nxt;
    idx          = 0;
    nxt          = 0;
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_req_eff[PTR_W'(idx)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = PTR_W'(idx);
      end
    end
    nxt = int'(w_pick_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    w_ptr_nxt = PTR_W'(nxt);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_do_grant   = 1'b0;
    w_do_capture = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (load_req) begin
          w_state_nxt  = ST_LOAD;
          w_do_capture = 1'b1;
        end else if (pause) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_do_grant = w_pick_valid;
        end
      end
      ST_HOLD: begin
        if (load_req) begin
          w_state_nxt  = ST_LOAD;
          w_do_capture = 1'b1;
        end else if (!pause) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: w_state_nxt = pause ? ST_HOLD : ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_counter  <= INIT_SEQ;
      r_load_num <= '0;
      r_rr_ptr   <= '0;
      grant      <= '0;
      seq_num    <= '0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
      wrap_flag  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      grant    <= '0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
      if (w_do_capture) r_load_num <= load_num;
      if (w_do_grant) begin
        grant     <= NUM_REQ'(1) << w_pick_idx;
        seq_num   <= r_counter;
        r_counter <= w_counter_nxt;
        r_rr_ptr  <= w_ptr_nxt;
        if (w_wrap) wrap_flag <= 1'b1;
      end
      if (r_state == ST_LOAD) begin
        if (w_load_ok) begin
          // A zero load is stored as 1 so the next issue is already bumped.
          r_counter <= (r_load_num == '0) ? SEQ_W'(1) : r_load_num;
          wrap_flag <= 1'b0;
          load_ack  <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_seq_alloc_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fix_seq_alloc_arbiter : scoreboard bench with a decimal reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fix_seq_alloc_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [23:0]  seq_num;
  logic         pause, load_req;
  logic [23:0]  load_num;
  logic         load_ack, load_err, wrap_flag, busy;

  fix_seq_alloc_arbiter #(.NUM_REQ(N), .DIGITS(6), .INIT_SEQ(24'h000002)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .seq_num   (seq_num),
    .pause     (pause),
    .load_req  (load_req),
    .load_num  (load_num),
    .load_ack  (load_ack),
    .load_err  (load_err),
    .wrap_flag (wrap_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic [N-1:0] g; logic [23:0] s; } gexp_t;
  typedef struct { int c; logic ack; } aexp_t;
  gexp_t gq[$];
  aexp_t aq[$];
  gexp_t ge;
  aexp_t ae;

  // Reference model: counter held as a plain decimal integer.
  int           m_cnt  = 2;
  int           m_rr   = 0;
  bit           m_wrap = 0;
  bit           m_load = 0;
  bit           m_hold = 0;
  logic [N-1:0] m_grant = '0;
  logic [23:0]  m_lnum = '0;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic p, input logic lr, input logic [23:0] ln);
    logic [N-1:0] elig;
    bit ok, found;
    int v, d, idx;
    @(negedge clk);
    check("wrap_flag", wrap_flag, m_wrap);
    req = r; pause = p; load_req = lr; load_num = ln;
    #1;
    check("busy", busy, m_load | p);
    if (m_load) begin
      ok = 1; v = 0;
      for (int i = 5; i >= 0; i--) begin
        d = int'(m_lnum[4*i +: 4]);
        if (d > 9) ok = 0;
        v = v * 10 + d;
      end
      if (ok) begin
        m_cnt  = (v == 0) ? 1 : v;
        m_wrap = 0;
      end
      aq.push_back('{cyc + 1, ok});
      m_load = 0; m_hold = p; m_grant = '0;
    end else if (lr) begin
      m_lnum = ln; m_load = 1; m_grant = '0;
    end else if (p) begin
      m_hold = 1; m_grant = '0;
    end else if (m_hold) begin
      m_hold = 0; m_grant = '0;
    end else begin
      elig = r & ~m_grant;
      m_grant = '0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && elig[idx]) begin
          found = 1;
          m_grant = N'(1) << idx;
          m_rr = (idx + 1) % N;
        end
      end
      if (found) begin
        gq.push_back('{cyc + 1, m_grant, to_bcd(m_cnt)});
        m_cnt++;
        if (m_cnt == 1000000) begin
          m_cnt = 1;
          m_wrap = 1;
        end
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or load response.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant != '0) begin
        if (gq.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
        else begin
          ge = gq.pop_front();
          check("grant", 32'(grant), 32'(ge.g));
          check("seq_num", 32'(seq_num), 32'(ge.s));
          check("grant_cycle", cyc, ge.c);
        end
      end else if (gq.size() > 0 && gq[0].c <= cyc) begin
        check("missing_grant", 32'd0, 32'(gq[0].g));
        void'(gq.pop_front());
      end
      if (load_ack || load_err) begin
        if (aq.size() == 0) check("unexpected_load_resp", {30'd0, load_ack, load_err}, 32'd0);
        else begin
          ae = aq.pop_front();
          check("load_ack", 32'(load_ack), 32'(ae.ack));
          check("load_err", 32'(load_err), 32'(!ae.ack));
          check("load_cycle", cyc, ae.c);
        end
      end else if (aq.size() > 0 && aq[0].c <= cyc) begin
        check("missing_load_resp", 32'd0, 32'd1);
        void'(aq.pop_front());
      end
    end
  end

  initial begin
    logic [N-1:0] rr;
    logic         rp, rl;
    logic [23:0]  rn;
    int           sel, kd;
    reset = 1'b1; req = '0; pause = 1'b0; load_req = 1'b0; load_num = '0;
    rp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_seq_num", 32'(seq_num), 32'd0);
    check("rst_load_ack", 32'(load_ack), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_wrap_flag", 32'(wrap_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single requester, held req ignored during its own grant.
    step(4'b0001, 0, 0, 0); step(4'b0001, 0, 0, 0); step(4'b0001, 0, 0, 0); step(4'b0000, 0, 0, 0);
    // All requesting: rotation.
    repeat (4) step(4'b1111, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    // Carry chain 000099 -> 000100.
    step(4'b0000, 0, 1, 24'h000099); step(4'b0000, 0, 0, 0);
    step(4'b0001, 0, 0, 0); step(4'b0000, 0, 0, 0); step(4'b0001, 0, 0, 0); step(4'b0000, 0, 0, 0);
    // Wrap 999999 -> 000001.
    step(4'b0000, 0, 1, 24'h999999); step(4'b0000, 0, 0, 0);
    step(4'b0010, 0, 0, 0); step(4'b0000, 0, 0, 0); step(4'b0010, 0, 0, 0); step(4'b0000, 0, 0, 0);
    // Load while requesting; second load_req during LOAD is ignored.
    step(4'b1111, 0, 1, 24'h004217); step(4'b1111, 0, 1, 24'h001111);
    step(4'b1111, 0, 0, 0); step(4'b1111, 0, 0, 0);
    // Bad digit rejected, then pause.
    step(4'b0000, 0, 1, 24'h0000A1); step(4'b0000, 0, 0, 0);
    repeat (3) step(4'b1111, 1, 0, 0);
    repeat (3) step(4'b1111, 0, 0, 0);
    // Zero load gets bumped to 1.
    step(4'b0000, 0, 1, 24'h000000); step(4'b0000, 0, 0, 0);
    step(4'b0100, 0, 0, 0); step(4'b0000, 0, 0, 0);
    // Load while paused lands in HOLD.
    step(4'b1111, 1, 1, 24'h000500); step(4'b1111, 1, 0, 0); step(4'b1111, 1, 0, 0);
    repeat (3) step(4'b1111, 0, 0, 0);

    for (int n = 0; n < 800; n++) begin
      rr = N'($urandom);
      if ($urandom_range(7) == 0) rp = ~rp;
      rl = ($urandom_range(15) == 0);
      sel = int'($urandom_range(4));
      case (sel)
        0: rn = 24'h000000;
        1: begin
          rn = to_bcd(int'($urandom_range(999999)));
          kd = int'($urandom_range(5));
          rn[4*kd +: 4] = 4'(10 + $urandom_range(5));
        end
        2: rn = to_bcd(999990 + int'($urandom_range(9)));
        default: rn = to_bcd(int'($urandom_range(999999)));
      endcase
      step(rr, rp, rl, rn);
    end

    repeat (4) step(4'b0000, 0, 0, 0);
    @(negedge clk);
    check("grant_queue_drained", gq.size(), 0);
    check("load_queue_drained", aq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
